// File: rtl/tpu_mac_sequencer.sv
// Dot-product job sequencer for an external 8x8->16 MAC: clear, stream LEN pairs, drain, report.
// Optional build macro TPU_SEQ_SATURATE_EN: an overflowed job reports res_data = 16'hFFFF.
module tpu_mac_sequencer #(
  parameter int LEN_W   = 8,
  parameter int MAC_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             cmd_ready,
  input  logic             op_valid,
  input  logic [7:0]       op_a,
  input  logic [7:0]       op_b,
  output logic             op_ready,
  output logic             mac_clr,
  output logic             mac_en,
  output logic [7:0]       mac_a,
  output logic [7:0]       mac_b,
  input  logic [15:0]      mac_acc,
  input  logic             mac_err,
  output logic             res_valid,
  output logic [15:0]      res_data,
  output logic             res_err,
  input  logic             res_ready
);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [2:0]       DRAIN_INIT = 3'(MAC_LAT);
  localparam logic [LEN_W-1:0] LEN_ONE    = LEN_W'(1);

  state_t           state;
  logic [LEN_W-1:0] remaining;
  logic [2:0]       drain_cnt;
  logic [15:0]      acc_result;

  assign cmd_ready = (state == S_IDLE);
  assign op_ready  = (state == S_RUN);

`ifdef TPU_SEQ_SATURATE_EN
  assign acc_result = mac_err ? 16'hFFFF : mac_acc;
`else
  assign acc_result = mac_acc;
`endif

  // DRAIN lasts MAC_LAT+1 cycles: the first one carries the last mac_en strobe,
  // the remaining MAC_LAT let the MAC pipeline settle before the sample.
  // NOTE: every register in this block uses <= so all updates see pre-edge values;
  // mixing in = here would make results depend on statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      remaining <= '0;
      drain_cnt <= '0;
      mac_clr   <= 1'b0;
      mac_en    <= 1'b0;
      mac_a     <= '0;
      mac_b     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_err   <= 1'b0;
    end else begin
      mac_clr <= 1'b0;
      mac_en  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            if (cmd_len != '0) begin
              remaining <= cmd_len;
              mac_clr   <= 1'b1;
              state     <= S_CLEAR;
            end else begin
              res_data  <= '0;
              res_err   <= 1'b0;
              res_valid <= 1'b1;
              state     <= S_DONE;
            end
          end
        end
        S_CLEAR: state <= S_RUN;
        S_RUN: begin
          if (op_valid) begin
            mac_a     <= op_a;
            mac_b     <= op_b;
            mac_en    <= 1'b1;
            remaining <= remaining - LEN_ONE;
            if (remaining == LEN_ONE) begin
              drain_cnt <= DRAIN_INIT;
              state     <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (drain_cnt == '0) begin
            res_data  <= acc_result;
            res_err   <= mac_err;
            res_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            drain_cnt <= drain_cnt - 3'd1;
          end
        end
        S_DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tpu_mac_sequencer.sv
// Scoreboard bench for tpu_mac_sequencer with a behavioural MAC and a sum-of-products reference.
// Honours TPU_SEQ_SATURATE_EN the same way the design does.
module tb_tpu_mac_sequencer;
  localparam int LEN_W   = 8;
  localparam int MAC_LAT = 1;
  localparam int TMO     = 3000;

  typedef struct {
    logic [15:0] data;
    logic        err;
    int          len;
    int          lat;   // expected cmd-accept -> res_valid cycles, -1 when not checked
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic [LEN_W-1:0] cmd_len;
  logic             cmd_ready;
  logic             op_valid;
  logic [7:0]       op_a, op_b;
  logic             op_ready;
  logic             mac_clr, mac_en;
  logic [7:0]       mac_a, mac_b;
  logic [15:0]      mac_acc;
  logic             mac_err;
  logic             res_valid;
  logic [15:0]      res_data;
  logic             res_err;
  logic             res_ready;
  logic             auto_rr, rr_rand, rr_man;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  int   oa[256];
  int   ob[256];

  always #5 clk = ~clk;

  tpu_mac_sequencer #(.LEN_W(LEN_W), .MAC_LAT(MAC_LAT)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_len(cmd_len), .cmd_ready(cmd_ready),
    .op_valid(op_valid), .op_a(op_a), .op_b(op_b), .op_ready(op_ready),
    .mac_clr(mac_clr), .mac_en(mac_en), .mac_a(mac_a), .mac_b(mac_b),
    .mac_acc(mac_acc), .mac_err(mac_err),
    .res_valid(res_valid), .res_data(res_data), .res_err(res_err), .res_ready(res_ready)
  );

  // External MAC: one-cycle multiply-accumulate with a sticky overflow flag
  always @(posedge clk) begin
    logic [16:0] s;
    if (reset) begin
      mac_acc <= '0;
      mac_err <= 1'b0;
    end else if (mac_clr) begin
      mac_acc <= '0;
      mac_err <= 1'b0;
    end else if (mac_en) begin
      s = {1'b0, mac_acc} + 17'(mac_a * mac_b);
      mac_acc <= s[15:0];
      mac_err <= mac_err | s[16];
    end
  end

  always @(posedge clk) begin
    #1 rr_rand = ($urandom_range(0, 2) != 0);
  end
  assign res_ready = auto_rr ? rr_rand : rr_man;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on each result handshake, plus protocol checks
  int          cyc = 0, acc_cyc = 0, en_cnt = 0;
  logic        prev_clr = 1'b0, prev_hold = 1'b0, prev_valid = 1'b0;
  logic [15:0] prev_data;
  logic        prev_err;
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (reset) begin
      prev_clr = 1'b0; prev_hold = 1'b0; prev_valid = 1'b0; en_cnt = 0;
    end else begin
      if (cmd_valid && cmd_ready) acc_cyc = cyc;
      if (mac_clr) begin
        if (prev_clr) check("mac_clr_width", {31'd0, prev_clr}, 32'd0);
        en_cnt = 0;
      end
      if (mac_en) en_cnt++;
      if (prev_hold) begin
        check("hold_valid", {31'd0, res_valid}, 32'd1);
        check("hold_data", {16'd0, res_data}, {16'd0, prev_data});
        check("hold_err", {31'd0, res_err}, {31'd0, prev_err});
      end
      if (res_valid && !prev_valid && sb.size() > 0 && sb[0].lat >= 0)
        check("latency", cyc - acc_cyc, sb[0].lat);
      if (res_valid && res_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_result", {31'd0, res_valid}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("res_data", {16'd0, res_data}, {16'd0, e.data});
          check("res_err", {31'd0, res_err}, {31'd0, e.err});
          check("mac_en_count", en_cnt, e.len);
        end
        en_cnt = 0;
      end
      prev_clr   = mac_clr;
      prev_valid = res_valid;
      prev_hold  = res_valid && !res_ready;
      prev_data  = res_data;
      prev_err   = res_err;
    end
  end

  task automatic wait_idle();
    int t = 0;
    while (!cmd_ready && t < TMO) begin @(posedge clk); #1; t++; end
    if (!cmd_ready) check("idle_timeout", {31'd0, cmd_ready}, 32'd1);
  endtask

  task automatic wait_drain();
    int t = 0;
    while (sb.size() != 0 && t < TMO) begin @(posedge clk); #1; t++; end
    if (sb.size() != 0) check("result_timeout", sb.size(), 0);
  endtask

  // Runs one job from oa/ob; gap_pct is the chance of an op_valid bubble per cycle
  task automatic do_job(input int len, input int gap_pct, input bit hold);
    exp_t e;
    int   sum = 0, idx = 0, t = 0;
    for (int i = 0; i < len; i++) sum += oa[i] * ob[i];
    e.err = (sum > 65535);
`ifdef TPU_SEQ_SATURATE_EN
    e.data = e.err ? 16'hFFFF : 16'(sum % 65536);
`else
    e.data = 16'(sum % 65536);
`endif
    e.len = len;
    e.lat = (len == 0) ? 1 : ((gap_pct == 0) ? len + MAC_LAT + 3 : -1);
    wait_idle();
    if (hold) begin auto_rr = 1'b0; rr_man = 1'b0; end
    sb.push_back(e);
    cmd_valid = 1'b1;
    cmd_len   = LEN_W'(len);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    while (idx < len && t < TMO) begin
      op_valid = ($urandom_range(0, 99) >= gap_pct);
      op_a = 8'(oa[idx]);
      op_b = 8'(ob[idx]);
      cmd_valid = ($urandom_range(0, 7) == 0);
      cmd_len   = LEN_W'($urandom_range(0, 9));
      @(negedge clk);
      if (cmd_valid) check("cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
      if (op_valid && op_ready) idx++;
      @(posedge clk); #1;
      t++;
    end
    if (idx != len) check("op_timeout", idx, len);
    op_valid  = 1'b0;
    cmd_valid = 1'b0;
    if (hold) begin
      t = 0;
      while (!res_valid && t < TMO) begin @(posedge clk); #1; t++; end
      check("hold_res_valid", {31'd0, res_valid}, 32'd1);
      for (int k = 0; k < 5; k++) begin
        cmd_valid = 1'b1;
        cmd_len   = LEN_W'(3);
        @(negedge clk);
        check("cmd_ready_done", {31'd0, cmd_ready}, 32'd0);
        @(posedge clk); #1;
      end
      cmd_valid = 1'b0;
      rr_man    = 1'b1;
      auto_rr   = 1'b1;
    end
    wait_drain();
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_len = '0; op_valid = 1'b0;
    op_a = '0; op_b = '0; auto_rr = 1'b1; rr_man = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_mac_en", {31'd0, mac_en}, 32'd0);
    check("rst_mac_clr", {31'd0, mac_clr}, 32'd0);
    check("rst_op_ready", {31'd0, op_ready}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    oa[0] = 13; ob[0] = 15;
    do_job(1, 0, 1'b0);
    oa[1] = 41; ob[1] = 47;
    do_job(2, 50, 1'b0);
    oa[0] = 255; ob[0] = 255; oa[1] = 255; ob[1] = 255;
    do_job(2, 0, 1'b0);
    oa[0] = 13; ob[0] = 15; oa[1] = 41; ob[1] = 47;
    do_job(2, 0, 1'b1);
    do_job(0, 0, 1'b0);

    // Reset after the first of three pairs: job abandoned, nothing reported
    wait_idle();
    cmd_valid = 1'b1; cmd_len = LEN_W'(3);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    op_valid = 1'b1; op_a = 8'd9; op_b = 8'd9;
    for (int t = 0; t < 10 && !op_ready; t++) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    op_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("midrst_res_valid", {31'd0, res_valid}, 32'd0);
    check("midrst_mac_en", {31'd0, mac_en}, 32'd0);
    check("midrst_mac_clr", {31'd0, mac_clr}, 32'd0);
    reset = 1'b0;
    oa[0] = 2; ob[0] = 3;
    do_job(1, 0, 1'b0);

    for (int j = 0; j < 25; j++) begin
      int len, big;
      len = (j == 0) ? 255 : $urandom_range(1, 40);
      big = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < len; i++) begin
        oa[i] = big ? $urandom_range(128, 255) : $urandom_range(0, 255);
        ob[i] = big ? $urandom_range(128, 255) : $urandom_range(0, 40);
      end
      do_job(len, (j % 3 == 0) ? 0 : 30, (j % 7 == 3));
    end

    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
